// File: rtl/pipe_ctrl.sv
// Purpose : hazard, forwarding, branch-flush and halt control for a 5-stage in-order pipeline.
// Latency : stall/flush/bubble/fwd_sel are combinational in the same cycle; hlt and retired are registered.
// Backpres: stall holds PC and IF/ID; bubble injects a NOP into ID/EX; flush kills IF/ID on a taken branch.
//
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   id_valid/id_hlt/id_we/id_ld ID-stage instruction flags
//   id_rd/id_src0/id_src1       ID-stage register addresses
//   id_use0/id_use1             ID instruction reads src0/src1
//   ex_br_taken                 branch in EX resolved taken
//   stall/flush/bubble          pipeline control
//   fwd_sel0/fwd_sel1           EX operand source: 00 RF, 01 EX/MEM, 10 MEM/WB
//   hlt                         processor halted
//   retired                     count of instructions reaching WB (wraps)
module pipe_ctrl #(
   parameter int RA       = 4,
   parameter int CNT_W    = 16,
   parameter int ZERO_REG = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             id_valid,
   input  logic             id_hlt,
   input  logic             id_we,
   input  logic             id_ld,
   input  logic [RA-1:0]    id_rd,
   input  logic [RA-1:0]    id_src0,
   input  logic [RA-1:0]    id_src1,
   input  logic             id_use0,
   input  logic             id_use1,
   input  logic             ex_br_taken,
   output logic             stall,
   output logic             flush,
   output logic             bubble,
   output logic [1:0]       fwd_sel0,
   output logic [1:0]       fwd_sel1,
   output logic             hlt,
   output logic [CNT_W-1:0] retired
);

   typedef struct packed {
      logic          v;
      logic          we;
      logic          ld;
      logic [RA-1:0] rd;
      logic [RA-1:0] src0;
      logic [RA-1:0] src1;
      logic          use0;
      logic          use1;
   } stage_t;

   typedef enum logic [1:0] {
      S_RUN    = 2'd0,
      S_DRAIN  = 2'd1,
      S_HALTED = 2'd2
   } state_t;

   state_t           r_state;
   logic [2:0]       r_drain_cnt;
   logic             r_hlt;
   stage_t           r_ex;
   stage_t           r_mem;
   stage_t           r_wb;
   logic [CNT_W-1:0] r_retired;

   stage_t w_id;
   logic   w_run;
   logic   w_load_use;
   logic   w_flush;
   logic   w_lu_stall;
   logic   w_halt_go;
   logic   w_stall;
   logic   w_bubble;
   logic   w_unused_wb;

   // A stage produces register a only if it is a live writer; r0 never
   // counts when it is hardwired to zero.
   function automatic logic f_match(input stage_t s, input logic [RA-1:0] a);
      return s.v && s.we && (s.rd == a) && !((ZERO_REG != 0) && (s.rd == '0));
   endfunction

   // MEM is the younger producer, so it wins over WB.
   function automatic logic [1:0] f_fwd(input logic use_n, input logic [RA-1:0] src);
      if (use_n && f_match(r_mem, src))
         return 2'b01;
      else if (f_match(r_wb, src))
         return 2'b10;
      else
         return 2'b00;
   endfunction

   always_comb begin
      w_id      = '0;
      w_id.v    = id_valid;
      w_id.we   = id_we;
      w_id.ld   = id_ld;
      w_id.rd   = id_rd;
      w_id.src0 = id_src0;
      w_id.src1 = id_src1;
      w_id.use0 = id_use0;
      w_id.use1 = id_use1;
   end

   assign w_run      = (r_state == S_RUN);
   assign w_load_use = id_valid && r_ex.ld &&
                       ((id_use0 && f_match(r_ex, id_src0)) ||
                        (id_use1 && f_match(r_ex, id_src1)));
   // A taken branch kills whatever sits in ID, so it pre-empts a load-use stall
   // and discards a halt waiting there.
   assign w_flush    = w_run && ex_br_taken;
   assign w_lu_stall = w_run && w_load_use && !ex_br_taken;
   assign w_halt_go  = w_run && id_valid && id_hlt && !ex_br_taken && !w_load_use;
   // Once draining or halted the front end is frozen and only NOPs enter EX.
   assign w_stall    = w_lu_stall || !w_run;
   assign w_bubble   = w_flush || w_lu_stall || w_halt_go || !w_run;

   // Control outputs are forced low while reset is held, whatever ID presents.
   assign stall    = rst_n && w_stall;
   assign flush    = rst_n && w_flush;
   assign bubble   = rst_n && w_bubble;
   assign fwd_sel0 = f_fwd(r_ex.use0, r_ex.src0);
   assign fwd_sel1 = f_fwd(r_ex.use1, r_ex.src1);
   assign hlt      = r_hlt;
   assign retired  = r_retired;

   // WB operand fields are kept so the shadow mirrors the real pipeline; only
   // v/we/rd are consulted there.
   assign w_unused_wb = ^{r_wb.ld, r_wb.src0, r_wb.src1, r_wb.use0, r_wb.use1};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_ex  <= '0;
         r_mem <= '0;
         r_wb  <= '0;
      end else begin
         r_wb   <= r_mem;
         r_mem  <= r_ex;
         r_ex   <= w_id;
         r_ex.v <= id_valid && !w_bubble;
      end
   end

   // Counting WB occupancy freezes the count naturally once the pipe drains.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         r_retired <= '0;
      else if (r_wb.v)
         r_retired <= r_retired + CNT_W'(1);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= S_RUN;
         r_drain_cnt <= 3'd0;
         r_hlt       <= 1'b0;
      end else begin
         case (r_state)
            S_RUN: begin
               if (w_halt_go) begin
                  r_state     <= S_DRAIN;
                  r_drain_cnt <= 3'd0;
               end
            end
            S_DRAIN: begin
               // Three drain cycles flush the EX, MEM and WB shadows.
               if (r_drain_cnt == 3'd2) begin
                  r_state <= S_HALTED;
                  r_hlt   <= 1'b1;
               end else begin
                  r_drain_cnt <= r_drain_cnt + 3'd1;
               end
            end
            S_HALTED: begin
               r_state <= S_HALTED;
               r_hlt   <= 1'b1;
            end
            default: begin
               r_state     <= S_RUN;
               r_drain_cnt <= 3'd0;
               r_hlt       <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_pipe_ctrl.sv
module tb_pipe_ctrl;

   logic        clk;
   logic        rst_n;
   logic        id_valid, id_hlt, id_we, id_ld;
   logic [3:0]  id_rd, id_src0, id_src1;
   logic        id_use0, id_use1;
   logic        ex_br_taken;
   logic        stall, flush, bubble, hlt;
   logic [1:0]  fwd_sel0, fwd_sel1;
   logic [15:0] retired;
   logic        unused_stall4, unused_flush4, unused_bubble4, unused_hlt4;
   logic [1:0]  unused_fwd04, unused_fwd14;
   logic [3:0]  retired4;

   pipe_ctrl #(.RA(4), .CNT_W(16), .ZERO_REG(1)) dut (
      .clk(clk), .rst_n(rst_n),
      .id_valid(id_valid), .id_hlt(id_hlt), .id_we(id_we), .id_ld(id_ld),
      .id_rd(id_rd), .id_src0(id_src0), .id_src1(id_src1),
      .id_use0(id_use0), .id_use1(id_use1), .ex_br_taken(ex_br_taken),
      .stall(stall), .flush(flush), .bubble(bubble),
      .fwd_sel0(fwd_sel0), .fwd_sel1(fwd_sel1), .hlt(hlt), .retired(retired)
   );

   // Narrow-counter copy sharing the same stimulus, for the wrap check.
   pipe_ctrl #(.RA(4), .CNT_W(4), .ZERO_REG(1)) dut4 (
      .clk(clk), .rst_n(rst_n),
      .id_valid(id_valid), .id_hlt(id_hlt), .id_we(id_we), .id_ld(id_ld),
      .id_rd(id_rd), .id_src0(id_src0), .id_src1(id_src1),
      .id_use0(id_use0), .id_use1(id_use1), .ex_br_taken(ex_br_taken),
      .stall(unused_stall4), .flush(unused_flush4), .bubble(unused_bubble4),
      .fwd_sel0(unused_fwd04), .fwd_sel1(unused_fwd14), .hlt(unused_hlt4),
      .retired(retired4)
   );

   typedef struct {
      string       name;
      logic        stall, flush, bubble, hlt;
      logic        chk_fwd;
      logic [1:0]  f0, f1;
      logic [15:0] ret;
   } exp_t;

   exp_t exp_q[$];
   int   n_checks = 0;
   int   n_errors = 0;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string nm, input string what,
                      input logic [15:0] act, input logic [15:0] req);
      n_checks++;
      if (act !== req) begin
         n_errors++;
         $display("FAIL %s %s: got %0h, expected %0h", nm, what, act, req);
      end
   endtask

   // Monitor: each cycle that has a pending expectation, compare the DUT
   // outputs away from the driving edge.
   always @(negedge clk) begin
      if (exp_q.size() > 0) begin
         exp_t e;
         e = exp_q.pop_front();
         chk(e.name, "stall",   16'(stall),   16'(e.stall));
         chk(e.name, "flush",   16'(flush),   16'(e.flush));
         chk(e.name, "bubble",  16'(bubble),  16'(e.bubble));
         chk(e.name, "hlt",     16'(hlt),     16'(e.hlt));
         chk(e.name, "retired", retired,      e.ret);
         chk(e.name, "retired4", 16'(retired4), 16'(e.ret[3:0]));
         if (e.chk_fwd) begin
            chk(e.name, "fwd_sel0", 16'(fwd_sel0), 16'(e.f0));
            chk(e.name, "fwd_sel1", 16'(fwd_sel1), 16'(e.f1));
         end
      end
   end

   // fl = {valid, hlt, we, ld}; us = {use0, use1}; ex = {stall, flush, bubble, hlt}
   task automatic step(input string nm, input logic rst, input logic [3:0] fl,
                       input logic [3:0] rd, input logic [3:0] s0, input logic [3:0] s1,
                       input logic [1:0] us, input logic br, input logic [3:0] ex,
                       input logic cf, input logic [1:0] e0, input logic [1:0] e1,
                       input int ret);
      exp_t e;
      @(posedge clk);
      #1;
      rst_n       = rst;
      id_valid    = fl[3];
      id_hlt      = fl[2];
      id_we       = fl[1];
      id_ld       = fl[0];
      id_rd       = rd;
      id_src0     = s0;
      id_src1     = s1;
      id_use0     = us[1];
      id_use1     = us[0];
      ex_br_taken = br;
      e.name    = nm;
      e.stall   = ex[3];
      e.flush   = ex[2];
      e.bubble  = ex[1];
      e.hlt     = ex[0];
      e.chk_fwd = cf;
      e.f0      = e0;
      e.f1      = e1;
      e.ret     = 16'(ret);
      exp_q.push_back(e);
   endtask

   task automatic nop(input string nm, input logic [3:0] ex, input logic cf,
                      input logic [1:0] e0, input logic [1:0] e1, input int ret);
      step(nm, 1'b1, 4'b0000, 4'd0, 4'd0, 4'd0, 2'b00, 1'b0, ex, cf, e0, e1, ret);
   endtask

   initial begin
      rst_n = 1'b0;
      id_valid = 0; id_hlt = 0; id_we = 0; id_ld = 0;
      id_rd = 0; id_src0 = 0; id_src1 = 0; id_use0 = 0; id_use1 = 0;
      ex_br_taken = 0;

      // Reset: outputs quiet even with live inputs
      step("rst_a", 0, 4'b1100, 0, 0, 0, 2'b00, 1, 4'b0000, 1, 0, 0, 0);
      step("rst_b", 0, 4'b1011, 3, 1, 2, 2'b11, 0, 4'b0000, 1, 0, 0, 0);

      // Load r3 then dependent add: one stall, then WB forwarding
      step("a1_ld",   1, 4'b1011, 3, 0, 0, 2'b00, 0, 4'b0000, 1, 0, 0, 0);
      step("a2_lu",   1, 4'b1010, 4, 3, 0, 2'b10, 0, 4'b1010, 1, 0, 0, 0);
      step("a3_held", 1, 4'b1010, 4, 3, 0, 2'b10, 0, 4'b0000, 0, 0, 0, 0);
      nop("a4_fwdwb", 4'b0000, 1, 2'b10, 2'b00, 0);
      nop("a5", 4'b0000, 1, 0, 0, 1);
      nop("a6", 4'b0000, 1, 0, 0, 1);

      // Back-to-back ALU dependency on src1: MEM forwarding, no stall
      step("b1_add", 1, 4'b1010, 5, 1, 2, 2'b11, 0, 4'b0000, 1, 0, 0, 2);
      step("b2_sub", 1, 4'b1010, 6, 7, 5, 2'b11, 0, 4'b0000, 1, 0, 0, 2);
      nop("b3_fwdmem", 4'b0000, 1, 2'b00, 2'b01, 2);
      nop("b4", 4'b0000, 1, 0, 0, 2);
      nop("b5", 4'b0000, 1, 0, 0, 3);

      // r8 in both MEM and WB: MEM wins
      step("c1_add8", 1, 4'b1010, 8, 0, 0, 2'b00, 0, 4'b0000, 1, 0, 0, 4);
      step("c2_add8", 1, 4'b1010, 8, 0, 0, 2'b00, 0, 4'b0000, 1, 0, 0, 4);
      step("c3_or",   1, 4'b1010, 9, 8, 8, 2'b11, 0, 4'b0000, 1, 0, 0, 4);
      nop("c4_prio", 4'b0000, 1, 2'b01, 2'b01, 4);
      nop("c5", 4'b0000, 1, 0, 0, 5);
      nop("c6", 4'b0000, 1, 0, 0, 6);

      // r0 is never a hazard or forwarding source
      step("d1_ld_r0", 1, 4'b1011, 0, 0, 0, 2'b00, 0, 4'b0000, 1, 0, 0, 7);
      step("d2_rd_r0", 1, 4'b1010, 10, 0, 0, 2'b11, 0, 4'b0000, 1, 0, 0, 7);
      nop("d3_r0fwd", 4'b0000, 1, 0, 0, 7);
      nop("d4", 4'b0000, 1, 0, 0, 7);
      nop("d5", 4'b0000, 1, 0, 0, 8);

      // Branch overrides load-use stall
      step("e1_ld",    1, 4'b1011, 2, 0, 0, 2'b00, 0, 4'b0000, 1, 0, 0, 9);
      step("e2_lu_br", 1, 4'b1010, 3, 0, 2, 2'b01, 1, 4'b0110, 1, 0, 0, 9);
      nop("e3", 4'b0000, 0, 0, 0, 9);
      nop("e4", 4'b0000, 1, 0, 0, 9);
      nop("e5", 4'b0000, 1, 0, 0, 10);
      step("e6_br", 1, 4'b0000, 0, 0, 0, 2'b00, 1, 4'b0110, 1, 0, 0, 10);

      // Halt sequence from a clean reset
      step("rst_c", 0, 4'b0000, 0, 0, 0, 2'b00, 0, 4'b0000, 1, 0, 0, 0);
      step("h1_hlt_br", 1, 4'b1100, 0, 0, 0, 2'b00, 1, 4'b0110, 1, 0, 0, 0);
      step("h2_add",    1, 4'b1010, 1, 0, 0, 2'b00, 0, 4'b0000, 1, 0, 0, 0);
      step("h3_add",    1, 4'b1010, 2, 0, 0, 2'b00, 0, 4'b0000, 1, 0, 0, 0);
      step("h4_hlt",    1, 4'b1100, 0, 0, 0, 2'b00, 0, 4'b0010, 1, 0, 0, 0);
      nop("h5_drain1", 4'b1010, 1, 0, 0, 0);
      nop("h6_drain2", 4'b1010, 1, 0, 0, 1);
      nop("h7_drain3", 4'b1010, 1, 0, 0, 2);
      step("h8_halt_br",  1, 4'b1100, 0, 0, 0, 2'b00, 1, 4'b1011, 1, 0, 0, 2);
      step("h9_halt_add", 1, 4'b1010, 1, 0, 0, 2'b00, 0, 4'b1011, 1, 0, 0, 2);
      step("h10_rst",     0, 4'b1100, 0, 0, 0, 2'b00, 1, 4'b0000, 1, 0, 0, 0);
      nop("h11_run", 4'b0000, 1, 0, 0, 0);
      step("h12_hlt",     1, 4'b1100, 0, 0, 0, 2'b00, 0, 4'b0010, 1, 0, 0, 0);
      nop("h13_drain", 4'b1010, 1, 0, 0, 0);
      step("h14_rst",     0, 4'b0000, 0, 0, 0, 2'b00, 0, 4'b0000, 1, 0, 0, 0);
      nop("h15_run", 4'b0000, 1, 0, 0, 0);

      // 17 ALU ops: wide counter reaches 17, 4-bit copy wraps to 1
      for (int k = 0; k <= 20; k++) begin
         int r;
         r = (k < 4) ? 0 : k - 3;
         if (k <= 16)
            step($sformatf("w%0d", k), 1, 4'b1010, 4'((k % 15) + 1), 0, 0,
                 2'b00, 0, 4'b0000, 1, 0, 0, r);
         else
            nop($sformatf("w%0d", k), 4'b0000, 1, 0, 0, r);
      end

      repeat (3) @(negedge clk);
      n_checks++;
      if (exp_q.size() != 0) begin
         n_errors++;
         $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   initial begin
      #50000;
      $display("FAIL timeout: simulation did not finish, limit 50000");
      $fatal(1);
   end

endmodule
